// File: rtl/truth_table_sweeper.sv
// Clocked truth-table sweep: drives every input vector onto a combinational
// block, waits SETTLE cycles, samples z and tallies mismatches against EXPECTED.
module truth_table_sweeper #(
  parameter int                        N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]      EXPECTED = 8'hEA,
  parameter int                        SETTLE   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] abc,
  input  logic            z,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam int              CNT_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE);
  localparam logic [N_IN-1:0]  LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  state_t            state, state_n;
  logic [N_IN-1:0]   idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [N_IN:0]     err_n;
  logic              ffv_n;
  logic [N_IN-1:0]   ffi_n;
  logic              busy_n, done_n, pass_n;
  logic              mismatch;

  // X or Z on the circuit output is treated as a failure, not a match.
  assign mismatch = (z !== EXPECTED[idx]);
  assign abc      = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      cnt              <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
    end else begin
      state            <= state_n;
      idx              <= idx_n;
      cnt              <= cnt_n;
      err_count        <= err_n;
      first_fail_valid <= ffv_n;
      first_fail_idx   <= ffi_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    err_n   = err_count;
    ffv_n   = first_fail_valid;
    ffi_n   = first_fail_idx;
    busy_n  = busy;
    done_n  = done;
    pass_n  = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = HOLD;
          idx_n   = '0;
          cnt_n   = CNT_LOAD;
          err_n   = '0;
          ffv_n   = 1'b0;
          ffi_n   = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end
      end
      HOLD: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_n = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          err_n = err_count + 1'b1;
          if (!first_fail_valid) begin
            ffv_n = 1'b1;
            ffi_n = idx;
          end
        end
        // pass is decided from the tally that includes this final compare.
        if (idx == LAST_IDX) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
        end else begin
          state_n = HOLD;
          idx_n   = idx + 1'b1;
          cnt_n   = CNT_LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
